// File: rtl/icache_pkg.sv
// icache_pkg
//   Shared definitions for the instruction cache responder: the fill FSM
//   state enum, the NOP used for fault/misalign responses, and helpers that
//   split a 64-bit fetch PC into word, index and tag fields.
//   Field layout (WB = log2 words/line, IB = log2 lines):
//     [1:0] byte, [WB+1:2] word, [IB+WB+1:WB+2] index, [63:IB+WB+2] tag
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      ERR  = 2'd2
   } ic_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   // Word-within-line field, right-justified.
   function automatic logic [63:0] get_word(input logic [63:0] pc, input int wb);
      return (pc >> 2) & ((64'd1 << wb) - 64'd1);
   endfunction

   // Line index field, right-justified.
   function automatic logic [63:0] get_index(input logic [63:0] pc, input int wb, input int ib);
      return (pc >> (wb + 2)) & ((64'd1 << ib) - 64'd1);
   endfunction

   // Everything above the index, right-justified.
   function automatic logic [63:0] get_tag(input logic [63:0] pc, input int wb, input int ib);
      return pc >> (ib + wb + 2);
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store
//   Valid/tag/data arrays of the direct-mapped instruction cache.
//   Ports:
//     CLK, reset        clock, synchronous active-high reset (clears valids)
//     clear_all         invalidate every line at the edge
//     inval_en/_index   invalidate one line (line about to be refilled)
//     rd_index/rd_word  combinational read address
//     rd_valid/rd_tag/rd_data  combinational read results
//     wr_en/wr_index/wr_word/wr_data  one-word data write
//     set_valid/wr_tag  write the tag of wr_index and mark it valid
module icache_line_store
   import icache_pkg::*;
#(
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4,
   parameter int TAG_W      = 56
) (
   input  logic                          CLK,
   input  logic                          reset,
   input  logic                          clear_all,
   input  logic                          inval_en,
   input  logic [$clog2(LINES)-1:0]      inval_index,
   input  logic [$clog2(LINES)-1:0]      rd_index,
   input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
   output logic                          rd_valid,
   output logic [TAG_W-1:0]              rd_tag,
   output logic [31:0]                   rd_data,
   input  logic                          wr_en,
   input  logic [$clog2(LINES)-1:0]      wr_index,
   input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
   input  logic [31:0]                   wr_data,
   input  logic                          set_valid,
   input  logic [TAG_W-1:0]              wr_tag
);

   localparam int IB = $clog2(LINES);
   localparam int WB = $clog2(LINE_WORDS);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES*LINE_WORDS];

   // Valid bits: a whole-cache clear wins; single-line invalidate and
   // set-valid never occur in the same cycle (one is IDLE, one is FILL).
   always_ff @(posedge CLK) begin
      if (reset || clear_all) begin
         valid_q <= '0;
      end else begin
         if (inval_en) begin
            valid_q[inval_index] <= 1'b0;
         end
         if (set_valid) begin
            valid_q[wr_index] <= 1'b1;
         end
      end
   end

   // Tag and data arrays carry no reset; the valid bit guards them.
   always_ff @(posedge CLK) begin
      if (set_valid) begin
         tag_q[wr_index] <= wr_tag;
      end
      if (wr_en) begin
         data_q[{wr_index, wr_word}] <= wr_data;
      end
   end

   // Combinational read port.
   always_comb begin
      rd_valid = valid_q[rd_index];
      rd_tag   = tag_q[rd_index];
      rd_data  = data_q[{rd_index, rd_word}];
   end

endmodule

// File: rtl/icache_responder.sv
// icache_responder
//   Direct-mapped instruction cache for the fetch stage. Hits and misaligned
//   fetches respond combinationally; misses fill the whole line word by word
//   over a request/ack memory port, then the request is re-evaluated.
//   Ports:
//     CLK, reset            clock, synchronous active-high reset
//     FE_PC, FE_REQ         fetch address and request
//     FLUSH                 fence.i, invalidate all lines
//     IC_R, IC_INSTR        response valid and instruction word
//     IC_IAF, IC_IAM        access fault / address misaligned qualifiers
//     MEM_REQ, MEM_ADDR     word read request to backing memory
//     MEM_ACK, MEM_DATA, MEM_ERR  memory response
module icache_responder
   import icache_pkg::*;
#(
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [63:0] FE_PC,
   input  logic        FE_REQ,
   input  logic        FLUSH,
   output logic        IC_R,
   output logic [31:0] IC_INSTR,
   output logic        IC_IAF,
   output logic        IC_IAM,
   output logic        MEM_REQ,
   output logic [63:0] MEM_ADDR,
   input  logic        MEM_ACK,
   input  logic [31:0] MEM_DATA,
   input  logic        MEM_ERR
);

   localparam int WB    = $clog2(LINE_WORDS);
   localparam int IB    = $clog2(LINES);
   localparam int TAG_W = 64 - IB - WB - 2;

   ic_state_e         state_q, state_d;
   logic [WB-1:0]     cnt_q;
   logic [63:0]       line_base_q;
   logic              flush_pend_q;

   logic [IB-1:0]     pc_index, fill_index;
   logic [WB-1:0]     pc_word;
   logic [TAG_W-1:0]  pc_tag, fill_tag;
   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [31:0]       rd_data;

   logic misaligned, hit, last_word, ack_ok, ack_err, fill_end;
   logic start_fill, flush_any, clear_all, wr_en, set_valid;

   assign pc_index   = IB'(get_index(FE_PC, WB, IB));
   assign pc_word    = WB'(get_word(FE_PC, WB));
   assign pc_tag     = TAG_W'(get_tag(FE_PC, WB, IB));
   assign fill_index = IB'(get_index(line_base_q, WB, IB));
   assign fill_tag   = TAG_W'(get_tag(line_base_q, WB, IB));

   // A flush in the request cycle turns a would-be hit into a miss.
   assign misaligned = FE_PC[1:0] != 2'b00;
   assign hit        = rd_valid && (rd_tag == pc_tag) && !FLUSH;
   assign last_word  = cnt_q == WB'(LINE_WORDS - 1);
   assign ack_ok     = (state_q == FILL) && MEM_ACK && !MEM_ERR;
   assign ack_err    = (state_q == FILL) && MEM_ACK && MEM_ERR;
   assign fill_end   = ack_err || (ack_ok && last_word);
   assign start_fill = (state_q == IDLE) && FE_REQ && !misaligned && !hit;
   assign flush_any  = FLUSH || flush_pend_q;

   // A flush that arrives while busy is deferred until the fill (or the
   // error response) finishes, so the in-flight line never becomes valid.
   assign clear_all  = ((state_q == IDLE) && FLUSH)
                     || (fill_end && flush_any)
                     || ((state_q == ERR) && flush_any);
   assign wr_en      = ack_ok && !reset;
   assign set_valid  = wr_en && last_word && !flush_any;

   icache_line_store #(
      .LINES      (LINES),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W)
   ) u_store (
      .CLK         (CLK),
      .reset       (reset),
      .clear_all   (clear_all),
      .inval_en    (start_fill && !reset),
      .inval_index (pc_index),
      .rd_index    (pc_index),
      .rd_word     (pc_word),
      .rd_valid    (rd_valid),
      .rd_tag      (rd_tag),
      .rd_data     (rd_data),
      .wr_en       (wr_en),
      .wr_index    (fill_index),
      .wr_word     (cnt_q),
      .wr_data     (MEM_DATA),
      .set_valid   (set_valid),
      .wr_tag      (fill_tag)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a miss starts a fill, the fill ends on the last
   // good ack or any error ack, and the error response lasts one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_fill) state_d = FILL;
         FILL: begin
            if (ack_err) begin
               state_d = ERR;
            end else if (ack_ok && last_word) begin
               state_d = IDLE;
            end
         end
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Fill bookkeeping: line base latched on the miss, word counter steps
   // on each good ack, and the deferred-flush flag.
   always_ff @(posedge CLK) begin
      if (reset) begin
         cnt_q        <= '0;
         line_base_q  <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         if (start_fill) begin
            cnt_q       <= '0;
            line_base_q <= {FE_PC[63:WB+2], {(WB+2){1'b0}}};
         end else if (ack_ok) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (clear_all) begin
            flush_pend_q <= 1'b0;
         end else if ((state_q != IDLE) && FLUSH) begin
            flush_pend_q <= 1'b1;
         end
      end
   end

   // Output logic; everything is held at zero while reset is asserted.
   always_comb begin
      IC_R     = 1'b0;
      IC_INSTR = 32'h0;
      IC_IAF   = 1'b0;
      IC_IAM   = 1'b0;
      MEM_REQ  = 1'b0;
      MEM_ADDR = 64'h0;
      if (!reset) begin
         case (state_q)
            IDLE: begin
               if (FE_REQ && misaligned) begin
                  IC_R     = 1'b1;
                  IC_IAM   = 1'b1;
                  IC_INSTR = NOP_INSTR;
               end else if (FE_REQ && hit) begin
                  IC_R     = 1'b1;
                  IC_INSTR = rd_data;
               end
            end
            FILL: begin
               MEM_REQ  = 1'b1;
               MEM_ADDR = line_base_q + 64'({cnt_q, 2'b00});
            end
            ERR: begin
               IC_R     = 1'b1;
               IC_IAF   = 1'b1;
               IC_INSTR = NOP_INSTR;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder
//   Self-checking bench for icache_responder (64 lines x 4 words). The bench
//   plays the backing memory (contents are a fixed function of the address)
//   and keeps a line-level model of which tags are resident per index.
module tb_icache_responder;

   localparam int LINES      = 64;
   localparam int LINE_WORDS = 4;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        CLK = 1'b0;
   logic        reset;
   logic [63:0] FE_PC;
   logic        FE_REQ;
   logic        FLUSH;
   logic        IC_R;
   logic [31:0] IC_INSTR;
   logic        IC_IAF;
   logic        IC_IAM;
   logic        MEM_REQ;
   logic [63:0] MEM_ADDR;
   logic        MEM_ACK;
   logic [31:0] MEM_DATA;
   logic        MEM_ERR;

   int          testsRun = 0;
   int          testsFailed = 0;
   logic [31:0] seedWord;

   // Model: per index, is a line resident and with which address tag.
   logic        refValid [LINES];
   logic [63:0] refTag   [LINES];

   icache_responder #(
      .LINES      (LINES),
      .LINE_WORDS (LINE_WORDS)
   ) dut (
      .CLK      (CLK),
      .reset    (reset),
      .FE_PC    (FE_PC),
      .FE_REQ   (FE_REQ),
      .FLUSH    (FLUSH),
      .IC_R     (IC_R),
      .IC_INSTR (IC_INSTR),
      .IC_IAF   (IC_IAF),
      .IC_IAM   (IC_IAM),
      .MEM_REQ  (MEM_REQ),
      .MEM_ADDR (MEM_ADDR),
      .MEM_ACK  (MEM_ACK),
      .MEM_DATA (MEM_DATA),
      .MEM_ERR  (MEM_ERR)
   );

   always #5 CLK = ~CLK;

   // Backing memory contents: any fixed address-dependent pattern works.
   function automatic logic [31:0] memWord(input logic [63:0] addr);
      return (addr[31:0] * 32'h9E3779B1) ^ seedWord ^ addr[63:32];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [63:0] pc, input logic req, input logic fl,
                                input logic ack, input logic [31:0] data, input logic err);
      FE_PC    = pc;
      FE_REQ   = req;
      FLUSH    = fl;
      MEM_ACK  = ack;
      MEM_DATA = data;
      MEM_ERR  = err;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clearModel();
      for (int i = 0; i < LINES; i++) refValid[i] = 1'b0;
   endtask

   // One fetch transaction. Called just after a clock edge with the DUT idle.
   // errWord/flushWord select the ack that carries MEM_ERR / FLUSH (-1: none).
   task automatic doFetch(input logic [63:0] pc, input int errWord,
                          input int flushWord, input int maxWait);
      int          idx;
      logic [63:0] tg;
      logic [63:0] base;
      logic        pend;
      idx  = int'((pc >> 4) % LINES);
      tg   = pc >> 10;
      base = pc & ~64'hF;
      pend = 1'b0;
      applyStimulus(pc, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      if (pc[1:0] != 2'b00) begin
         checkOutput("iam_r", IC_R, 1);
         checkOutput("iam_flag", IC_IAM, 1);
         checkOutput("iam_iaf", IC_IAF, 0);
         checkOutput("iam_instr", IC_INSTR, NOP);
         checkOutput("iam_memreq", MEM_REQ, 0);
         FE_REQ = 1'b0;
         step();
         return;
      end
      if (refValid[idx] && refTag[idx] == tg) begin
         checkOutput("hit_r", IC_R, 1);
         checkOutput("hit_instr", IC_INSTR, memWord(pc));
         checkOutput("hit_memreq", MEM_REQ, 0);
         FE_REQ = 1'b0;
         step();
         return;
      end
      checkOutput("miss_r", IC_R, 0);
      step();
      for (int k = 0; k < LINE_WORDS; k++) begin
         int waits;
         waits = $urandom_range(0, maxWait);
         for (int w = 0; w < waits; w++) begin
            applyStimulus(pc, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            #1;
            checkOutput("wait_memreq", MEM_REQ, 1);
            checkOutput("wait_addr", MEM_ADDR, base + 64'(4 * k));
            step();
         end
         applyStimulus(pc, 1'b1, (k == flushWord), 1'b1,
                       (k == errWord) ? 32'hDEAD_BEEF : memWord(base + 64'(4 * k)),
                       (k == errWord));
         #1;
         checkOutput("fill_memreq", MEM_REQ, 1);
         checkOutput("fill_addr", MEM_ADDR, base + 64'(4 * k));
         checkOutput("fill_r", IC_R, 0);
         if (k == flushWord) pend = 1'b1;
         step();
         if (k == errWord) begin
            applyStimulus(pc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            #1;
            checkOutput("err_r", IC_R, 1);
            checkOutput("err_iaf", IC_IAF, 1);
            checkOutput("err_iam", IC_IAM, 0);
            checkOutput("err_instr", IC_INSTR, NOP);
            checkOutput("err_memreq", MEM_REQ, 0);
            refValid[idx] = 1'b0;
            if (pend) clearModel();
            step();
            checkOutput("err_oneshot_iaf", IC_IAF, 0);
            checkOutput("err_oneshot_r", IC_R, 0);
            return;
         end
      end
      // Back in IDLE: the same request is re-evaluated.
      applyStimulus(pc, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      if (pend) begin
         clearModel();
      end else begin
         refValid[idx] = 1'b1;
         refTag[idx]   = tg;
      end
      #1;
      if (pend) begin
         checkOutput("postflush_r", IC_R, 0);
      end else begin
         checkOutput("filled_r", IC_R, 1);
         checkOutput("filled_instr", IC_INSTR, memWord(pc));
         checkOutput("filled_memreq", MEM_REQ, 0);
      end
      FE_REQ = 1'b0;
      step();
   endtask

   initial begin
      logic [63:0] pc;
      seedWord = $urandom;
      clearModel();
      applyStimulus(64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
      checkOutput("reset_r", IC_R, 0);
      checkOutput("reset_iaf", IC_IAF, 0);
      checkOutput("reset_iam", IC_IAM, 0);
      checkOutput("reset_memreq", MEM_REQ, 0);
      checkOutput("reset_addr", MEM_ADDR, 0);
      checkOutput("reset_instr", IC_INSTR, 0);
      step();

      // Cold miss, zero-wait memory, then hit on the third word.
      doFetch(64'h1000, -1, -1, 0);
      doFetch(64'h1008, -1, -1, 0);
      // Conflict at index 0, then the old line misses again and errors.
      doFetch(64'h1400, -1, -1, 1);
      doFetch(64'h1000, 1, -1, 0);
      doFetch(64'h1000, -1, -1, 2);
      // Misaligned fetch.
      doFetch(64'h1002, -1, -1, 0);
      // Flush mid-fill: the line completes but stays invalid, then refetch.
      doFetch(64'h2000, -1, 2, 1);
      doFetch(64'h2000, -1, -1, 0);
      doFetch(64'h2004, -1, -1, 0);

      // Flush in IDLE alongside a request to a resident line: no hit.
      applyStimulus(64'h2004, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("idleflush_r", IC_R, 0);
      FE_REQ = 1'b0;
      step();
      FLUSH = 1'b0;
      clearModel();
      doFetch(64'h2004, -1, -1, 0);

      // Reset mid-fill, then a late ack in IDLE, then everything misses.
      applyStimulus(64'h3000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      #1;
      checkOutput("midfill_memreq", MEM_REQ, 1);
      reset = 1'b1;
      step();
      reset  = 1'b0;
      FE_REQ = 1'b0;
      #1;
      checkOutput("postreset_memreq", MEM_REQ, 0);
      checkOutput("postreset_addr", MEM_ADDR, 0);
      checkOutput("postreset_r", IC_R, 0);
      MEM_ACK  = 1'b1;
      MEM_DATA = 32'h1234_5678;
      step();
      MEM_ACK = 1'b0;
      #1;
      checkOutput("lateack_memreq", MEM_REQ, 0);
      checkOutput("lateack_r", IC_R, 0);
      step();
      clearModel();
      doFetch(64'h2004, -1, -1, 0);

      // Randomized traffic over a small address pool to mix hits, conflicts,
      // bus errors, misaligned fetches and flushes.
      for (int n = 0; n < 150; n++) begin
         int errW, flW;
         pc = 64'h8000 + (64'($urandom_range(0, 3)) << 10)
                       + (64'($urandom_range(0, 7)) << 4)
                       + (64'($urandom_range(0, 3)) << 2);
         if ($urandom_range(0, 15) == 0) pc = pc + 64'($urandom_range(1, 3));
         errW = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
         flW  = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 3)) : -1;
         if ($urandom_range(0, 19) == 0) begin
            applyStimulus(pc, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            step();
            FLUSH = 1'b0;
            clearModel();
         end
         doFetch(pc, errW, flW, 2);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/icache_responder.md
# icache_responder

Instruction-side responder for the fetch stage. Takes the fetch PC and request, and returns an instruction word with ready/fault status. It is a direct-mapped instruction cache with a line-fill state machine on the miss path, behind which sits a simple word-wide request/ack memory port. A hit returns the word in the same cycle; a miss stalls fetch (`IC_R=0`) until the line is filled.

## Interface
- `LINES`, default 64: number of cache lines; power of two.
- `LINE_WORDS`, default 4: 32-bit words per line; power of two, at least 2.
- `CLK`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `FE_PC`, in, 64: fetch PC.
- `FE_REQ`, in, 1: fetch requests the instruction at `FE_PC` this cycle.
- `FLUSH`, in, 1: fence.i; invalidate all lines.
- `IC_R`, out, 1: response valid this cycle (hit, fault or misalign).
- `IC_INSTR`, out, 32: instruction word; meaningful only when `IC_R=1`.
- `IC_IAF`, out, 1: instruction access fault; qualifies `IC_R`.
- `IC_IAM`, out, 1: instruction address misaligned; qualifies `IC_R`.
- `MEM_REQ`, out, 1: word read request to backing memory.
- `MEM_ADDR`, out, 64: word-aligned read address.
- `MEM_ACK`, in, 1: memory returns `MEM_DATA`/`MEM_ERR` this cycle.
- `MEM_DATA`, in, 32: read data.
- `MEM_ERR`, in, 1: bus error on this ack.

## Operation
- **Address split** (with WB = log2(`LINE_WORDS`) and IB = log2(`LINES`)):
  - byte offset = `PC[1:0]`
  - word = `PC[WB+1:2]`
  - index = `PC[IB+WB+1:WB+2]`
  - tag = the remaining upper bits
- **Storage:** per line, a valid bit, a tag and `LINE_WORDS` data words. Reads are combinational.
- **States:** IDLE, FILL, ERR.
- **IDLE:**
  - `FE_REQ && PC[1:0]!=0`: `IC_R=1`, `IC_IAM=1`, `IC_INSTR=32'h00000013`. No fill.
  - `FE_REQ` and hit (valid and tag match): `IC_R=1`, `IC_INSTR` = the stored word.
  - `FE_REQ` and miss: `IC_R=0`. Latch the line base address. Clear the word counter. Go to FILL.
- **FILL:**
  - `MEM_REQ=1`, `MEM_ADDR` = line base + counter×4.
  - Address stays stable until `MEM_ACK`.
  - Each ack with `MEM_ERR=0` writes `MEM_DATA` into the counter slot and increments the counter.
  - Ack on the last word: write tag, set valid (unless a flush is pending), go to IDLE.
  - Ack with `MEM_ERR=1`: line stays invalid, go to ERR.
  - `IC_R=0` throughout.
- **ERR:** for exactly one cycle, `IC_R=1`, `IC_IAF=1`, `IC_INSTR=32'h00000013`. Then IDLE.
- **PC change during a fill:** does not abort the fill. The response on return to IDLE is re-evaluated against the current `FE_PC`.
- **`FLUSH`:**
  - In IDLE: clears all valid bits at the edge. A request in the same cycle is treated as a miss.
  - In FILL or ERR: sets flush-pending. The in-flight line completes but is not marked valid. All valid bits are cleared on the cycle the fill ends.
- **`reset`:** at any time, including mid-fill:
  - state = IDLE, all valid bits = 0, counter = 0, flush-pending = 0.
  - The `MEM_REQ` flop is forced to 0. Any late `MEM_ACK` is ignored in IDLE.
- **Reset values:** `IC_R=0`, `IC_IAF=0`, `IC_IAM=0`, `MEM_REQ=0`, `MEM_ADDR=0`, `IC_INSTR=0`.

## Timing
- Hit or misalign: combinational response in the request cycle.
- Miss detected at cycle T: FILL from T+1, and `MEM_REQ` is high from T+1.
- With a zero-wait memory (ack in the request cycle), the words are acked at T+1…T+`LINE_WORDS`. The hit is then returned at T+`LINE_WORDS`+1.
- Memory may hold `MEM_ACK` low for any number of cycles. `MEM_REQ` and `MEM_ADDR` stay stable until it is acked.
- `IC_IAF` is exactly one cycle long. `IC_IAF` and `IC_IAM` are never set together.

## Structure
- Package `icache_pkg`:
  - state enum (IDLE/FILL/ERR)
  - `NOP_INSTR = 32'h00000013`
  - helper functions for the index, word and tag fields
- Sub-module `icache_line_store`: valid/tag/data arrays, with a combinational read port and a one-word write port.
- The top level holds the FSM, word counter, flush-pending flag and response muxing.

## Test plan
- **Cold miss:** reset, then `FE_REQ` with PC=`0x1000`.
  - `MEM_ADDR` steps `0x1000`, `0x1004`, `0x1008`, `0x100C`.
  - Then `IC_R=1` with the word written at `0x1000`.
- **Hit after fill:** PC=`0x1008` → `IC_R=1` in the same cycle, `IC_INSTR` = the third filled word, `MEM_REQ=0`.
- **Conflict:** PC=`0x1400` (index 0, new tag) → refill from `0x1400`. Then PC=`0x1000` misses again.
- **Bus error:** `MEM_ERR` on the second ack.
  - One-cycle `IC_R=1`, `IC_IAF=1`, `IC_INSTR=0x13`.
  - Re-requesting `0x1000` starts a new fill.
- **Misaligned:** PC=`0x1002` → `IC_R=1` and `IC_IAM=1` in the same cycle, no `MEM_REQ`.
- **Flush mid-fill, then reset mid-fill:**
  - Flush mid-fill: the fill completes, the line stays invalid, and the next request refetches.
  - Reset mid-fill: `MEM_REQ=0` the next cycle and every line misses.
